// File: rtl/memoria_instrucciones_cargable.sv
// +----------------------------------------------------------------------------+
// | memoria_instrucciones_cargable: loadable fetch-stage instruction memory.   |
// | Rev 1.0 - optional per-word even parity enabled by MEM_INSTR_PARIDAD_EN.   |
// +----------------------------------------------------------------------------+
`default_nettype none

module memoria_instrucciones_cargable #(
  parameter int                    ANCHO_DATO  = 32,
  parameter int                    ANCHO_DIR   = 10,
  parameter int                    PROFUNDIDAD = 1024,
  parameter logic [ANCHO_DATO-1:0] NOP         = {ANCHO_DATO{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ANCHO_DIR-1:0]  direccion,
  input  logic                  leer,
  input  logic                  detener,
  input  logic                  vaciar,
  output logic [ANCHO_DATO-1:0] instruccion,
  output logic                  valida,
  input  logic                  carga_en,
  input  logic [ANCHO_DIR-1:0]  carga_dir,
  input  logic [ANCHO_DATO-1:0] carga_dato,
  input  logic                  carga_fin,
  output logic                  listo,
  output logic                  error_dir,
  output logic                  error_carga
`ifdef MEM_INSTR_PARIDAD_EN
  ,
  output logic                  error_paridad
`endif
);

`ifdef MEM_INSTR_PARIDAD_EN
  localparam int ANCHO_MEM = ANCHO_DATO + 1;
`else
  localparam int ANCHO_MEM = ANCHO_DATO;
`endif
  localparam logic [ANCHO_DIR:0]   LIMITE = (ANCHO_DIR + 1)'(PROFUNDIDAD);
  localparam logic [ANCHO_DIR-1:0] ULTIMA = ANCHO_DIR'(PROFUNDIDAD - 1);

  typedef enum logic [1:0] {
    LIMPIAR   = 2'd0,
    CARGA     = 2'd1,
    EJECUCION = 2'd2
  } estado_t;

  estado_t               estado, estado_sig;
  logic [ANCHO_DIR-1:0]  contador, contador_sig;
  logic                  escribir;
  logic [ANCHO_DIR-1:0]  dir_esc;
  logic [ANCHO_DATO-1:0] dato_esc;
  logic [ANCHO_MEM-1:0]  palabra_esc;
  logic [ANCHO_MEM-1:0]  lectura;
  logic                  carga_en_rango;
  logic                  fetch_en_rango;

  logic [ANCHO_MEM-1:0]  mem [0:PROFUNDIDAD-1];

  assign carga_en_rango = ({1'b0, carga_dir} < LIMITE);
  assign fetch_en_rango = ({1'b0, direccion} < LIMITE);
  assign listo          = (estado == EJECUCION);

  always_comb begin
    estado_sig   = estado;
    contador_sig = contador;
    escribir     = 1'b0;
    dir_esc      = contador;
    dato_esc     = NOP;
    case (estado)
      LIMPIAR: begin
        escribir = 1'b1;
        if (contador == ULTIMA) begin
          estado_sig   = CARGA;
          contador_sig = '0;
        end else begin
          contador_sig = contador + 1'b1;
        end
      end
      CARGA: begin
        escribir = carga_en && carga_en_rango;
        dir_esc  = carga_dir;
        dato_esc = carga_dato;
        if (carga_fin) begin
          estado_sig = EJECUCION;
        end
      end
      EJECUCION: begin
        estado_sig = EJECUCION;
      end
      default: begin
        estado_sig   = LIMPIAR;
        contador_sig = '0;
      end
    endcase
  end

`ifdef MEM_INSTR_PARIDAD_EN
  assign palabra_esc = {^dato_esc, dato_esc};
`else
  assign palabra_esc = dato_esc;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado   <= LIMPIAR;
      contador <= '0;
    end else begin
      estado   <= estado_sig;
      contador <= contador_sig;
    end
  end

  // Array is never written on a reset edge, so an interrupted clear leaves old words in place.
  always_ff @(posedge clk) begin
    if (reset && escribir) begin
      mem[dir_esc] <= palabra_esc;
    end
  end

  assign lectura = mem[direccion];

  always_ff @(posedge clk) begin
    if (!reset) begin
      instruccion   <= NOP;
      valida        <= 1'b0;
      error_dir     <= 1'b0;
`ifdef MEM_INSTR_PARIDAD_EN
      error_paridad <= 1'b0;
`endif
    end else if (estado == EJECUCION) begin
      if (vaciar) begin
        instruccion <= NOP;
        valida      <= 1'b0;
      end else if (detener) begin
        instruccion <= instruccion;
      end else if (leer && fetch_en_rango) begin
        instruccion   <= lectura[ANCHO_DATO-1:0];
        valida        <= 1'b1;
        error_dir     <= 1'b0;
`ifdef MEM_INSTR_PARIDAD_EN
        error_paridad <= ^lectura;
`endif
      end else begin
        instruccion   <= NOP;
        valida        <= 1'b0;
        error_dir     <= leer;
`ifdef MEM_INSTR_PARIDAD_EN
        error_paridad <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      error_carga <= 1'b0;
    end else if (carga_en && ((estado == EJECUCION) ||
                              ((estado == CARGA) && !carga_en_rango))) begin
      error_carga <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memoria_instrucciones_cargable.sv
// Scoreboard bench for memoria_instrucciones_cargable: default-depth instance plus a 1000-word instance.
`default_nettype none

module tb_memoria_instrucciones_cargable;

  localparam logic [31:0] NOP = 32'h00000000;
  localparam logic [31:0] X1  = 32'h20420020;
  localparam logic [31:0] X2  = 32'h20630001;
  localparam logic [31:0] X3  = 32'h00432006;
  localparam logic [31:0] X4  = 32'h13572468;
  localparam logic [31:0] X5  = 32'h0BADF00D;

  logic        clk;
  logic        rst_a, rst_b;
  logic [9:0]  direccion;
  logic        leer, detener, vaciar;
  logic        carga_en, carga_fin;
  logic [9:0]  carga_dir;
  logic [31:0] carga_dato;

  logic [31:0] instr_a, instr_b;
  logic        valida_a, valida_b, listo_a, listo_b;
  logic        edir_a, edir_b, ecarga_a, ecarga_b;
`ifdef MEM_INSTR_PARIDAD_EN
  logic        par_a, par_b;
`endif

  memoria_instrucciones_cargable dut (
    .clk(clk), .reset(rst_a), .direccion(direccion), .leer(leer),
    .detener(detener), .vaciar(vaciar), .instruccion(instr_a), .valida(valida_a),
    .carga_en(carga_en), .carga_dir(carga_dir), .carga_dato(carga_dato),
    .carga_fin(carga_fin), .listo(listo_a), .error_dir(edir_a),
    .error_carga(ecarga_a)
`ifdef MEM_INSTR_PARIDAD_EN
    , .error_paridad(par_a)
`endif
  );

  memoria_instrucciones_cargable #(.PROFUNDIDAD(1000)) dut_b (
    .clk(clk), .reset(rst_b), .direccion(direccion), .leer(leer),
    .detener(detener), .vaciar(vaciar), .instruccion(instr_b), .valida(valida_b),
    .carga_en(carga_en), .carga_dir(carga_dir), .carga_dato(carga_dato),
    .carga_fin(carga_fin), .listo(listo_b), .error_dir(edir_b),
    .error_carga(ecarga_b)
`ifdef MEM_INSTR_PARIDAD_EN
    , .error_paridad(par_b)
`endif
  );

  typedef struct {
    int          ciclo;
    string       nombre;
    bit          b;
    logic [31:0] instr;
    logic        val, edir, ecarga, listo;
  } esperado_t;

  esperado_t cola[$];
  int  ciclo = 0;
  int  n_aserciones = 0;
  int  n_fallos = 0;
  bit  sel_b = 1'b0;
  logic m_ecarga = 1'b0;
  logic m_listo = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ciclo <= ciclo + 1;

  // Monitor: pops every expectation due at this edge and compares against the selected instance.
  initial begin
    esperado_t   e;
    logic [35:0] act, exp_v;
    forever begin
      @(posedge clk);
      #1;
      while (cola.size() > 0 && cola[0].ciclo <= ciclo) begin
        e = cola.pop_front();
        if (e.b) act = {instr_b, valida_b, edir_b, ecarga_b, listo_b};
        else     act = {instr_a, valida_a, edir_a, ecarga_a, listo_a};
        exp_v = {e.instr, e.val, e.edir, e.ecarga, e.listo};
        n_aserciones++;
        if (act !== exp_v || e.ciclo != ciclo) begin
          n_fallos++;
          $display("FAIL %s @%0d: got instr=%h valida=%b error_dir=%b error_carga=%b listo=%b, expected instr=%h valida=%b error_dir=%b error_carga=%b listo=%b",
                   e.nombre, ciclo, act[35:4], act[3], act[2], act[1], act[0],
                   e.instr, e.val, e.edir, e.ecarga, e.listo);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of stimulus");
    $fatal(1, "timeout");
  end

  task automatic paso(input bit chk, input string nom, input logic [31:0] ei,
                      input logic ev, input logic ed);
    esperado_t e;
    if (chk) begin
      e.ciclo  = ciclo + 1;
      e.nombre = nom;
      e.b      = sel_b;
      e.instr  = ei;
      e.val    = ev;
      e.edir   = ed;
      e.ecarga = m_ecarga;
      e.listo  = m_listo;
      cola.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic l, input logic [9:0] d, input logic det, input logic vac);
    leer = l; direccion = d; detener = det; vaciar = vac;
  endtask

  task automatic cargar(input logic en, input logic [9:0] d, input logic [31:0] v, input logic fin);
    carga_en = en; carga_dir = d; carga_dato = v; carga_fin = fin;
  endtask

  task automatic reset_a;
    rst_a = 1'b0; m_ecarga = 1'b0; m_listo = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    fetch(0, 10'd0, 0, 0);
    cargar(0, 10'd0, 32'h0, 0);
    @(negedge clk);
    paso(1, "reset_a", NOP, 0, 0);

    // S1: interrupted clear, then restart timed by a held carga_fin
    rst_a = 1'b1;
    repeat (300) paso(0, "", NOP, 0, 0);
    reset_a();
    paso(1, "reset_mid_clear", NOP, 0, 0);
    rst_a = 1'b1;
    fetch(1, 10'd0, 0, 0);
    cargar(0, 10'd3, X4, 1);
    for (int i = 0; i < 1024; i++) paso(i == 0 || i == 1023, "clear_restart", NOP, 0, 0);
    cargar(1, 10'd3, X4, 1);
    m_listo = 1'b1;
    paso(1, "fin_with_load", NOP, 0, 0);
    cargar(0, 10'd0, 32'h0, 0);
    fetch(1, 10'd3, 0, 0); paso(1, "fetch3_same_cycle_load", X4, 1, 0);
    fetch(1, 10'd0, 0, 0); paso(1, "fetch0_cleared", NOP, 1, 0);

    // S2: full load and fetch tests
    reset_a();
    paso(1, "reset_in_exec", NOP, 0, 0);
    rst_a = 1'b1;
    fetch(0, 10'd0, 0, 0);
    for (int i = 0; i < 1024; i++) paso(i == 1023, "clear2", NOP, 0, 0);
    fetch(1, 10'd0, 0, 0);
    cargar(1, 10'd0, X1, 0); paso(1, "load0_no_fetch", NOP, 0, 0);
    cargar(1, 10'd1, X2, 0); paso(0, "", NOP, 0, 0);
    cargar(1, 10'd2, X3, 0); paso(0, "", NOP, 0, 0);
    cargar(1, 10'd5, 32'hDEADBEEF, 0); paso(1, "load5", NOP, 0, 0);
    cargar(0, 10'd0, 32'h0, 1); fetch(0, 10'd0, 0, 0);
    m_listo = 1'b1;
    paso(1, "carga_fin", NOP, 0, 0);
    cargar(0, 10'd0, 32'h0, 0);
    fetch(1, 10'd0, 0, 0);    paso(1, "b2b_0", X1, 1, 0);
    fetch(1, 10'd1, 0, 0);    paso(1, "b2b_1", X2, 1, 0);
    fetch(1, 10'd2, 0, 0);    paso(1, "b2b_2", X3, 1, 0);
    fetch(1, 10'd500, 0, 0);  paso(1, "fetch500", NOP, 1, 0);
    fetch(1, 10'd1023, 0, 0); paso(1, "fetch1023", NOP, 1, 0);
    fetch(1, 10'd5, 0, 0);    paso(1, "fetch5", 32'hDEADBEEF, 1, 0);
    fetch(1, 10'd3, 0, 0);    paso(1, "fetch3_recleared", NOP, 1, 0);
    fetch(1, 10'd1, 0, 0);    paso(1, "pre_stall", X2, 1, 0);
    fetch(1, 10'd2, 1, 0);
    for (int i = 0; i < 3; i++) paso(1, "stall_hold", X2, 1, 0);
    fetch(1, 10'd2, 1, 1);    paso(1, "flush_over_stall", NOP, 0, 0);
    fetch(0, 10'd2, 0, 0);    paso(1, "idle", NOP, 0, 0);
    cargar(1, 10'd0, 32'hFFFFFFFF, 0);
    m_ecarga = 1'b1;
    paso(1, "illegal_load_exec", NOP, 0, 0);
    cargar(0, 10'd0, 32'h0, 0);
    fetch(1, 10'd0, 0, 0);    paso(1, "after_illegal_load", X1, 1, 0);

    // S3: reset during CARGA, clear restarts and wipes the earlier program
    reset_a();
    paso(1, "reset_s3", NOP, 0, 0);
    rst_a = 1'b1;
    fetch(0, 10'd0, 0, 0);
    for (int i = 0; i < 1024; i++) paso(0, "", NOP, 0, 0);
    cargar(1, 10'd7, 32'hCAFE0007, 0); paso(0, "", NOP, 0, 0);
    cargar(0, 10'd0, 32'h0, 0);
    reset_a();
    paso(1, "reset_in_carga", NOP, 0, 0);
    rst_a = 1'b1;
    cargar(0, 10'd0, 32'h0, 1);
    for (int i = 0; i < 1024; i++) paso(i == 1023, "clear3_timing", NOP, 0, 0);
    cargar(1, 10'd4, X5, 1);
    m_listo = 1'b1;
    paso(1, "fin3", NOP, 0, 0);
    cargar(0, 10'd0, 32'h0, 0);
    fetch(1, 10'd0, 0, 0); paso(1, "s3_word0", NOP, 1, 0);
    fetch(1, 10'd1, 0, 0); paso(1, "s3_word1", NOP, 1, 0);
    fetch(1, 10'd2, 0, 0); paso(1, "s3_word2", NOP, 1, 0);
    fetch(1, 10'd5, 0, 0); paso(1, "s3_word5", NOP, 1, 0);
    fetch(1, 10'd7, 0, 0); paso(1, "s3_word7", NOP, 1, 0);
    fetch(1, 10'd4, 0, 0); paso(1, "s3_word4", X5, 1, 0);

    // Bounds on the 1000-word instance
    reset_a();
    fetch(0, 10'd0, 0, 0);
    sel_b = 1'b1;
    paso(1, "reset_b", NOP, 0, 0);
    rst_b = 1'b1;
    for (int i = 0; i < 1000; i++) paso(i == 999, "clear_b", NOP, 0, 0);
    cargar(1, 10'd1000, 32'hFFFFFFFF, 0);
    m_ecarga = 1'b1;
    paso(1, "load_oob", NOP, 0, 0);
    cargar(1, 10'd999, 32'h12345678, 0); paso(1, "load999", NOP, 0, 0);
    cargar(0, 10'd0, 32'h0, 1);
    m_listo = 1'b1;
    paso(1, "fin_b", NOP, 0, 0);
    cargar(0, 10'd0, 32'h0, 0);
    fetch(1, 10'd999, 0, 0);  paso(1, "b_fetch999", 32'h12345678, 1, 0);
    fetch(1, 10'd1000, 0, 0); paso(1, "b_fetch1000", NOP, 0, 1);
    fetch(1, 10'd999, 1, 0);  paso(1, "b_stall_err", NOP, 0, 1);
    paso(1, "b_stall_err2", NOP, 0, 1);
    fetch(1, 10'd1023, 0, 0); paso(1, "b_fetch1023", NOP, 0, 1);
    fetch(1, 10'd0, 0, 0);    paso(1, "b_fetch0", NOP, 1, 0);
    fetch(1, 10'd999, 0, 0);  paso(1, "b_fetch999_again", 32'h12345678, 1, 0);
    fetch(0, 10'd0, 0, 0);    paso(1, "b_idle", NOP, 0, 0);

    repeat (3) @(negedge clk);
    n_aserciones++;
    if (cola.size() != 0) begin
      n_fallos++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", cola.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_aserciones, n_fallos);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memoria_instrucciones_cargable.md
Name: memoria_instrucciones_cargable

Overview:
Parametrised instruction memory for the pipeline fetch stage: synchronous-read ROM-style array with run-time program loading, so test programs are no longer hard-coded in the RTL. On reset the array is cleared to NOP. A loader then writes the program. The fetch stage reads with 1-cycle latency and has stall and flush control.

Parameters:
ANCHO_DATO, 32, instruction width in bits
ANCHO_DIR, 10, address width in bits
PROFUNDIDAD, 1024, number of words (must be ≤ 2**ANCHO_DIR)
NOP, 32'h00000000, fill/bubble word (HLT encoding)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
direccion  in  ANCHO_DIR  fetch address (word index)
leer  in  1  fetch request
detener  in  1  stall: hold fetch output registers
vaciar  in  1  flush: inject bubble
instruccion  out  ANCHO_DATO  fetched word, registered
valida  out  1  instruccion is a real fetched word
carga_en  in  1  loader write strobe
carga_dir  in  ANCHO_DIR  loader write address
carga_dato  in  ANCHO_DATO  loader write data
carga_fin  in  1  loader done pulse
listo  out  1  high in EJECUCION state
error_dir  out  1  registered; last fetch address ≥ PROFUNDIDAD
error_carga  out  1  sticky; illegal or out-of-range load write

Behaviour:
- Reset (reset=0 at an edge): state=LIMPIAR, contador=0, instruccion=NOP, valida=0, listo=0, error_dir=0, error_carga=0. Array contents are not touched on the reset edge itself.
- Reset asserted in any state, including mid-clear or mid-load, aborts the operation. After reset is released, clearing restarts from word 0.
- State LIMPIAR:
  - Each cycle writes NOP to word contador, then contador+1.
  - After word PROFUNDIDAD-1 is written, go to CARGA. Clearing takes exactly PROFUNDIDAD cycles.
  - leer, carga_en and carga_fin are ignored.
- State CARGA:
  - carga_en=1 with carga_dir<PROFUNDIDAD writes carga_dato at that edge.
  - carga_dir≥PROFUNDIDAD: write dropped, error_carga set.
  - carga_fin=1: go to EJECUCION next cycle. If carga_en is in the same cycle, that write is still performed.
  - Fetch is ignored; valida=0.
- State EJECUCION: listo=1. carga_en=1 is dropped and sets error_carga. There is no exit except reset.
- Fetch in EJECUCION, priority order per edge:
  1. vaciar=1: instruccion←NOP, valida←0. Overrides detener.
  2. detener=1: instruccion, valida and error_dir hold.
  3. leer=1, direccion<PROFUNDIDAD: instruccion←array[direccion], valida←1, error_dir←0.
  4. leer=1, direccion≥PROFUNDIDAD: instruccion←NOP, valida←0, error_dir←1.
  5. leer=0: instruccion←NOP, valida←0, error_dir←0.
- Fetch latency: address sampled at edge N, data visible after edge N, i.e. usable in cycle N+1.
- Back-to-back fetches sustain one word per cycle.
- No read/write collision is possible, because loads and fetches occur in disjoint states.
- Array is a single-port synchronous array inferable as block RAM. It has no initial block.

Optional Feature:
MEM_INSTR_PARIDAD_EN
- Defined:
  - Each word stores an extra even-parity bit, computed on load and NOP-clear writes.
  - On a successful fetch (case 3), the stored parity is checked.
  - Extra output error_paridad (1 bit, reset 0) is registered alongside instruccion. It is 1 when the check fails and follows the same hold/flush rules as error_dir.
- Undefined: no parity storage and no error_paridad port. Behaviour is otherwise identical.

Test Plan:
- Clear: release reset, hold carga_en=0 → listo=0 for 1024 cycles. Enter CARGA, assert carga_fin → listo=1 one cycle later. Fetch addr 0, 500, 1023 → 32'h00000000, valida=1.
- Load and fetch: load [0]=32'h20420020, [1]=32'h20630001, [2]=32'h00432006, then carga_fin. Fetch 0,1,2 back-to-back → the same words appear one cycle after each address, valida=1 continuously.
- Stall and flush: fetch 1 then assert detener for 3 cycles while direccion=2 → output holds 32'h20630001. Assert vaciar together with detener → next cycle NOP, valida=0.
- Bounds, with PROFUNDIDAD=1000: fetch 1000 → NOP, valida=0, error_dir=1. Load to 1000 during CARGA → error_carga=1, no array change.
- Illegal load: in EJECUCION, carga_en with addr 0, data 32'hFFFFFFFF → error_carga=1, and fetch 0 still returns 32'h20420020.
- Reset mid-operation: assert reset during LIMPIAR at contador=300 and again during CARGA → full 1024-cycle clear restarts, and previously loaded words read back as NOP.
